// File: rtl/popcount_decoder_pkg.sv
// popcount_decoder_pkg
//   Shared definitions for the popcount decoder and its companion
//   ones-counter: FSM state encodings, count/word widths and the index of
//   the final serial bit.
package popcount_decoder_pkg;

  localparam int COUNT_W = 3;
  localparam int WORD_W  = 7;

  // Bit counter value at which the seventh (last) serial bit is on the line.
  localparam logic [COUNT_W-1:0] LAST_BIT = 3'd6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/popcount_decoder_therm_lut.sv
// popcount_decoder_therm_lut
//   Combinational 3 -> 7 thermometer decode: bit i of word is 1 iff i < count.
// Ports:
//   count  in   3-bit count 0..7
//   word   out  7-bit thermometer word ((1 << count) - 1)
module popcount_decoder_therm_lut
  import popcount_decoder_pkg::*;
(
  input  logic [COUNT_W-1:0] count,
  output logic [WORD_W-1:0]  word
);

  // Table decode of the count into its thermometer pattern.
  always_comb begin
    word = 7'h00;
    case (count)
      3'd0:    word = 7'h00;
      3'd1:    word = 7'h01;
      3'd2:    word = 7'h03;
      3'd3:    word = 7'h07;
      3'd4:    word = 7'h0F;
      3'd5:    word = 7'h1F;
      3'd6:    word = 7'h3F;
      3'd7:    word = 7'h7F;
      default: word = 7'h00;
    endcase
  end

endmodule

// File: rtl/popcount_decoder.sv
// popcount_decoder
//   Accepts a 3-bit count over valid/ready, regenerates the 7-bit
//   thermometer word with that many ones, and serializes it LSB-first.
//   One word per 9 cycles: 7 serial bits, one done cycle, one idle cycle.
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   in_count   in   count to decode (0..7)
//   in_valid   in   in_count valid this cycle
//   in_ready   out  high only while idle
//   therm_out  out  thermometer word of the last accepted count
//   ser_out    out  serial data bit (0 when ser_valid is low)
//   ser_valid  out  ser_out carries a live bit
//   done       out  one-cycle pulse after the last serial bit
module popcount_decoder
  import popcount_decoder_pkg::*;
#(
  parameter int WIDTH = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COUNT_W-1:0] in_count,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   therm_out,
  output logic               ser_out,
  output logic               ser_valid,
  output logic               done
);

  state_e              state_r;
  logic [WORD_W-1:0]   shift_r;
  logic [COUNT_W-1:0]  bitcnt_r;
  logic [WORD_W-1:0]   load_word_s;

  popcount_decoder_therm_lut u_therm_lut (
    .count (in_count),
    .word  (load_word_s)
  );

  // FSM, shift register, bit counter and all registered outputs.
  // ser_out is registered as the bit that sits in shift_r[0] after the same
  // edge, so it mirrors shift_r[0] throughout SHIFT without a combinational path.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      shift_r   <= 7'h00;
      bitcnt_r  <= 3'd0;
      therm_out <= 7'h00;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      done      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready) begin
            state_r   <= SHIFT;
            therm_out <= load_word_s;
            shift_r   <= load_word_s;
            bitcnt_r  <= 3'd0;
            ser_out   <= load_word_s[0];
            ser_valid <= 1'b1;
            done      <= 1'b0;
            in_ready  <= 1'b0;
          end else begin
            state_r   <= IDLE;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            done      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        SHIFT: begin
          shift_r <= {1'b0, shift_r[WORD_W-1:1]};
          if (bitcnt_r == LAST_BIT) begin
            state_r   <= DONE;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            done      <= 1'b1;
          end else begin
            bitcnt_r  <= bitcnt_r + 3'd1;
            ser_out   <= shift_r[1];
            ser_valid <= 1'b1;
          end
        end
        DONE: begin
          state_r   <= IDLE;
          ser_out   <= 1'b0;
          ser_valid <= 1'b0;
          done      <= 1'b0;
          in_ready  <= 1'b1;
        end
        default: begin
          state_r   <= IDLE;
          ser_out   <= 1'b0;
          ser_valid <= 1'b0;
          done      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/popcount_decoder.md
# popcount_decoder

Inverse of the lab's 7-input ones-counter: accepts a 3-bit count (0–7) over a valid/ready handshake and regenerates the canonical 7-bit thermometer word with that many ones. It also serializes the word LSB-first on a 1-bit line, so a downstream ones-counter can rebuild and re-count it. It sits between the count source (the encoder output or a test driver) and any consumer of the parallel or serial pattern.

## Interface
- WIDTH, 7, thermometer word width; count width is fixed at 3 bits and only WIDTH = 7 is supported.
- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- in_count  input  3  count to decode; legal values 0–7.
- in_valid  input  1  in_count is valid this cycle.
- in_ready  output  1  block can accept; high only in IDLE.
- therm_out  output  7  thermometer word; bit i = 1 iff i < latched count.
- ser_out  output  1  serial data bit.
- ser_valid  output  1  ser_out carries a live bit.
- done  output  1  one-cycle pulse after the last serial bit.

## Operation
- States:
  - IDLE: in_ready = 1.
  - SHIFT: 7 cycles; shift register drives ser_out.
  - DONE: 1 cycle; done = 1, in_ready = 0.
- Transitions:
  - IDLE → SHIFT on in_valid & in_ready (accept).
  - SHIFT → DONE when the 3-bit bit counter reaches 6.
  - DONE → IDLE unconditionally.
- On accept: therm_out <= (7'b1 << in_count) − 1, truncated to 7 bits. Count 7 gives 7'h7F and count 0 gives 7'h00.
  - The shift register loads the same word and the bit counter clears to 0.
- SHIFT:
  - ser_out = shift_reg[0] and ser_valid = 1.
  - Shift right with zero fill each cycle; increment the bit counter.
- therm_out holds its value from accept until the next accept. It is unaffected by DONE or IDLE.
- in_valid outside IDLE is ignored; no buffering. Source data must remain valid until accepted.
- All 3-bit values are legal; no error output.

## Timing
- Reset values: state = IDLE, therm_out = 0, ser_out = 0, ser_valid = 0, done = 0, in_ready = 1, bit counter = 0.
- Accept at edge N (in_valid & in_ready sampled high):
  - Edges N+1 to N+7: therm_out valid from N+1; ser bits 0–6 present.
  - N+8: done = 1.
  - N+9: in_ready = 1 again.
- Throughput: one word per 9 cycles. Back-to-back: in_valid held high is accepted at N, N+9, N+18, …
- ser_out = 0 whenever ser_valid = 0.
- rst asserted in any state, including mid-SHIFT or during DONE:
  - Next edge gives reset values.
  - No done pulse for the aborted word; therm_out clears.
- rst and in_valid high together: reset wins, nothing is accepted.

## Structure
- Shared include file holds:
  - State encodings: IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2.
  - COUNT_W = 3 and WORD_W = 7 localparams, reused by the encoder bench.
- One sub-module is natural: `therm_lut`, a combinational 3 → 7 thermometer decode. It is instantiated once for the load value.
- Everything else lives in one module: FSM, bit counter, shift register, output registers.

## Test plan
- Reset release with in_valid = 0 for 10 cycles → in_ready = 1; therm_out, ser_valid and done all 0.
- Accept in_count = 3 → therm_out = 7'b0000111 from N+1.
  - ser_out sequence 1,1,1,0,0,0,0 with ser_valid high for exactly 7 cycles.
  - done at N+8; in_ready at N+9.
- Sweep in_count 0–7 → therm_out = 00, 01, 03, 07, 0F, 1F, 3F, 7F (hex). The ser_out ones total equals in_count.
  - Loop back through the lab ones-counter; its output equals in_count.
- in_valid held high with in_count = 5, then 2 → accepts exactly at N and N+9.
  - in_count changes during SHIFT are ignored.
  - therm_out = 1F, then 03.
- Assert rst at N+4, mid-SHIFT → next cycle all outputs at reset values, no done pulse.
  - Fresh accept of in_count = 7 then completes normally with 7 ones.
